// File: rtl/frame_stream_out.sv
// frame_stream_out
//   Reads a completed frame back from the output memory in raster order
//   (addresses 0..WIDTH*HEIGHT-1) and emits it on a valid/ready pixel stream
//   with start-of-frame, end-of-line and end-of-frame markers. A 2-entry
//   buffer absorbs the memory's 1-cycle read latency and sink backpressure.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   start                    frame-ready level from the controller
//   en_out_mem, out_mem_read read strobe, high only on read-issue cycles
//   out_mem_addr             read address (0 when no read is issued)
//   out_mem_data             read data, valid the cycle after the issue
//   pix_data, pix_valid,
//   pix_ready                pixel stream handshake
//   pix_sof/eol/eof          frame markers, qualified by pix_valid
//   busy                     reading or draining a frame
//   frame_done               frame fully transferred; waits for start=0
module frame_stream_out #(
    parameter int WIDTH  = 800,
    parameter int HEIGHT = 600,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              en_out_mem,
    output logic              out_mem_read,
    output logic [ADDR_W-1:0] out_mem_addr,
    input  logic [DATA_W-1:0] out_mem_data,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              busy,
    output logic              frame_done
);

    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int ENT_W = DATA_W + 3;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                      state_q, state_d;
    logic [ADDR_W-1:0]           issue_cnt_q, issue_cnt_d;
    logic [COL_W-1:0]            col_q, col_d;
    logic [ROW_W-1:0]            row_q, row_d;
    logic                        ret_q, ret_d;
    logic                        ret_sof_q, ret_sof_d;
    logic                        ret_eol_q, ret_eol_d;
    logic                        ret_eof_q, ret_eof_d;
    logic [1:0][ENT_W-1:0]       buf_q, buf_d;
    logic                        wr_ptr_q, wr_ptr_d;
    logic                        rd_ptr_q, rd_ptr_d;
    logic [1:0]                  occ_q, occ_d;

    logic                        pop;
    logic                        issue;
    logic [2:0]                  pending;
    logic [ENT_W-1:0]            head;

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        col_d       = col_q;
        row_d       = row_q;
        buf_d       = buf_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;

        pop = (occ_q != 2'd0) && pix_ready;
        // Entries that will still hold a slot after this edge: the buffer
        // minus this cycle's pop plus the read returning now. A read issued
        // now lands one cycle later, so it fits whenever this is below 2.
        pending = 3'(occ_q) + 3'(ret_q) - 3'(pop);
        issue   = (state_q == S_RUN) && (pending < 3'd2);

        case (state_q)
            S_IDLE: begin
                issue_cnt_d = '0;
                col_d       = '0;
                row_d       = '0;
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                if (issue) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (issue_cnt_q == LAST_ADDR) state_d = S_DRAIN;
                end
            end
            // Every read is issued by now, so an empty buffer with nothing
            // returning means the eof pixel has left the block.
            S_DRAIN: begin
                if (occ_q == 2'd0 && !ret_q) state_d = S_DONE;
            end
            S_DONE: begin
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        ret_d     = issue;
        ret_sof_d = issue && (col_q == '0) && (row_q == '0);
        ret_eol_d = issue && (col_q == LAST_COL);
        ret_eof_d = issue && (col_q == LAST_COL) && (row_q == LAST_ROW);

        if (ret_q) begin
            buf_d[wr_ptr_q] = {out_mem_data, ret_sof_q, ret_eol_q, ret_eof_q};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        occ_d = occ_q + {1'b0, ret_q} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            col_q       <= '0;
            row_q       <= '0;
            ret_q       <= 1'b0;
            ret_sof_q   <= 1'b0;
            ret_eol_q   <= 1'b0;
            ret_eof_q   <= 1'b0;
            buf_q       <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            occ_q       <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            ret_q       <= ret_d;
            ret_sof_q   <= ret_sof_d;
            ret_eol_q   <= ret_eol_d;
            ret_eof_q   <= ret_eof_d;
            buf_q       <= buf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
        end
    end

    assign en_out_mem   = issue;
    assign out_mem_read = issue;
    assign out_mem_addr = issue ? issue_cnt_q : '0;

    assign head       = buf_q[rd_ptr_q];
    assign pix_data   = head[ENT_W-1:3];
    assign pix_sof    = head[2];
    assign pix_eol    = head[1];
    assign pix_eof    = head[0];
    assign pix_valid  = (occ_q != 2'd0);
    assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_frame_stream_out.sv
// tb_frame_stream_out
//   Scoreboard bench for frame_stream_out. A 4x3 instance is exercised with
//   several ready patterns, start held through DONE and a mid-frame reset; a
//   1x1 instance covers the single-pixel frame. Expected pixels are queued
//   when a frame is started and popped by per-instance monitors on transfer.
module tb_frame_stream_out;

    localparam int AW = 4;
    localparam int AH = 3;
    localparam int AN = AW * AH;

    logic        clk;
    logic        rst;

    logic        a_start, a_en, a_rd, a_valid, a_ready;
    logic        a_sof, a_eol, a_eof, a_busy, a_done;
    logic [31:0] a_addr;
    logic [7:0]  a_mdata, a_pdata;

    logic        b_start, b_en, b_rd, b_valid, b_ready;
    logic        b_sof, b_eol, b_eof, b_busy, b_done;
    logic [31:0] b_addr;
    logic [7:0]  b_mdata, b_pdata;

    int          checks = 0;
    int          errors = 0;
    int          ready_mode = 0;
    int          issues_total = 0;
    int          a_issued = 0;
    int          a_xfer = 0;
    int          a_next_addr = 0;
    logic        a_stall = 1'b0;
    logic [10:0] a_held = '0;

    logic [10:0] qa[$];
    logic [10:0] qb[$];

    frame_stream_out #(.WIDTH(AW), .HEIGHT(AH), .DATA_W(8), .ADDR_W(32)) u_a (
        .clk(clk), .rst(rst), .start(a_start),
        .en_out_mem(a_en), .out_mem_read(a_rd), .out_mem_addr(a_addr),
        .out_mem_data(a_mdata),
        .pix_data(a_pdata), .pix_valid(a_valid), .pix_ready(a_ready),
        .pix_sof(a_sof), .pix_eol(a_eol), .pix_eof(a_eof),
        .busy(a_busy), .frame_done(a_done)
    );

    frame_stream_out #(.WIDTH(1), .HEIGHT(1), .DATA_W(8), .ADDR_W(32)) u_b (
        .clk(clk), .rst(rst), .start(b_start),
        .en_out_mem(b_en), .out_mem_read(b_rd), .out_mem_addr(b_addr),
        .out_mem_data(b_mdata),
        .pix_data(b_pdata), .pix_valid(b_valid), .pix_ready(b_ready),
        .pix_sof(b_sof), .pix_eol(b_eol), .pix_eof(b_eof),
        .busy(b_busy), .frame_done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories: A holds mem[a]=a, B holds a^8'h5A.
    always @(posedge clk) if (a_en) a_mdata <= a_addr[7:0];
    always @(posedge clk) if (b_en) b_mdata <= b_addr[7:0] ^ 8'h5A;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Reference frame: data = address, markers from raster position.
    task automatic push_frame_a();
        for (int i = 0; i < AN; i++)
            qa.push_back({8'(i), (i == 0), ((i % AW) == AW - 1), (i == AN - 1)});
    endtask

    task automatic wait_done_a(input int budget);
        for (int k = 0; k < budget && !a_done; k++) @(negedge clk);
        check("a_frame_done", a_done, 1);
        check("a_all_pixels_seen", qa.size(), 0);
    endtask

    // Ready driver: 0 = always 1, 1 = pattern 1,0,0,1, 2 = held 0, 3 = random.
    initial begin
        int pat;
        pat = 0;
        a_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: a_ready = 1'b1;
                1: begin
                    a_ready = (pat == 0) || (pat == 3);
                    pat = (pat + 1) % 4;
                end
                2: a_ready = 1'b0;
                default: a_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor A: issue protocol, hold stability, outstanding bound, scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            a_next_addr = 0;
            a_issued    = 0;
            a_xfer      = 0;
            a_stall     = 1'b0;
        end else begin
            check("a_read_eq_en", a_rd, a_en);
            if (a_en) begin
                check("a_issue_addr", a_addr, 64'(a_next_addr));
                a_next_addr++;
                a_issued++;
                issues_total++;
            end else begin
                check("a_idle_addr", a_addr, 0);
            end
            if (a_stall)
                check("a_head_hold", {a_valid, a_pdata, a_sof, a_eol, a_eof},
                      {1'b1, a_held});
            a_stall = a_valid && !a_ready;
            a_held  = {a_pdata, a_sof, a_eol, a_eof};
            if (a_valid && a_ready) begin
                check("a_sb_nonempty", (qa.size() > 0), 1);
                if (qa.size() > 0)
                    check("a_pixel", {a_pdata, a_sof, a_eol, a_eof}, qa.pop_front());
                a_xfer++;
            end
            check("a_outstanding_le2", ((a_issued - a_xfer) <= 2), 1);
            if (!a_busy && !a_done) begin
                a_next_addr = 0;
                a_issued    = 0;
                a_xfer      = 0;
            end
        end
    end

    // Monitor B: single-pixel frame, sink always ready.
    always @(negedge clk) begin
        if (rst) begin
            check("b_read_eq_en", b_rd, b_en);
            check("b_addr", b_addr, 0);
            if (b_valid) begin
                check("b_sb_nonempty", (qb.size() > 0), 1);
                if (qb.size() > 0)
                    check("b_pixel", {b_pdata, b_sof, b_eol, b_eof}, qb.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before the sequence ended");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int snap;
        rst     = 1'b0;
        a_start = 1'b0;
        b_start = 1'b0;
        b_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("a_reset_outputs",
              {a_en, a_rd, a_addr, a_pdata, a_valid, a_sof, a_eol, a_eof, a_busy, a_done}, 0);
        check("b_reset_outputs",
              {b_en, b_rd, b_addr, b_pdata, b_valid, b_sof, b_eol, b_eof, b_busy, b_done}, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Frame 1: ready held 1, start held high through DONE.
        ready_mode = 0;
        @(negedge clk);
        a_start = 1'b1;
        push_frame_a();
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (a_valid) begin
                lat = k;
                break;
            end
        end
        check("a_first_valid_latency", lat, 3);
        wait_done_a(200);
        snap = issues_total;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("a_done_held", {a_done, a_busy}, 2'b10);
        end
        #1;
        check("a_no_restart_issues", issues_total - snap, 0);

        // Frame 2: start dropped for one cycle, ready 1,0,0,1.
        a_start = 1'b0;
        @(negedge clk);
        ready_mode = 1;
        a_start = 1'b1;
        push_frame_a();
        wait_done_a(300);
        a_start = 1'b0;

        // Frame 3: ready held 0 for 20 cycles, then 1.
        ready_mode = 2;
        repeat (2) @(negedge clk);
        #1;
        snap = issues_total;
        @(negedge clk);
        a_start = 1'b1;
        push_frame_a();
        repeat (20) @(negedge clk);
        #1;
        check("a_stall_issue_count", issues_total - snap, 2);
        check("a_stall_head", {a_valid, a_pdata, a_sof}, {1'b1, 8'h00, 1'b1});
        ready_mode = 0;
        wait_done_a(200);
        a_start = 1'b0;

        // Frame 4: random ready, reset once pixel 5 has transferred.
        ready_mode = 3;
        repeat (2) @(negedge clk);
        a_start = 1'b1;
        push_frame_a();
        for (int k = 0; k < 300 && a_xfer < 6; k++) begin
            @(negedge clk);
            #1;
        end
        check("a_reached_pixel5", (a_xfer >= 6), 1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        a_start = 1'b0;
        qa.delete();
        #1;
        check("a_midframe_reset_outputs",
              {a_en, a_rd, a_addr, a_pdata, a_valid, a_sof, a_eol, a_eof, a_busy, a_done}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Frame 5: clean restart from address 0 with sof.
        ready_mode = 0;
        @(negedge clk);
        a_start = 1'b1;
        push_frame_a();
        wait_done_a(200);
        a_start = 1'b0;

        // Single-pixel frame on the 1x1 instance.
        @(negedge clk);
        b_start = 1'b1;
        qb.push_back({8'h5A, 1'b1, 1'b1, 1'b1});
        for (int k = 0; k < 50 && !b_done; k++) @(negedge clk);
        check("b_frame_done", b_done, 1);
        check("b_all_pixels_seen", qb.size(), 0);
        b_start = 1'b0;
        repeat (3) @(negedge clk);
        check("b_back_to_idle", {b_done, b_busy}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
